// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder answering READ (0x03): decodes command and address,
// fetches 32-bit words over a req/ack port and streams bytes MSB-first on MISO.
module spi_flash_responder #(
  parameter logic [7:0]  CMD_READ = 8'h03,
  parameter int unsigned ADDR_W   = 24
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              spi_sck,
  input  logic              spi_ss,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              err_underrun
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DATA   = 3'd3,
    ST_IGNORE = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic r_sck_s1, r_sck_s2, r_sck_d;
  logic r_ss_s1, r_ss_s2;
  logic r_mosi_s1, r_mosi_s2;
  logic r_rise, r_fall;

  logic [5:0]        r_bit_cnt;
  logic [6:0]        r_cmd;
  logic [ADDR_W-2:0] r_addr;
  logic [1:0]        r_byte_idx;
  logic [2:0]        r_bit_idx;
  logic [ADDR_W-1:0] r_word_addr;
  logic [31:0]       r_cur_word;
  logic              r_cur_valid;
  logic [31:0]       r_hold_word;
  logic              r_hold_valid;
  logic              r_miso;
  logic              r_err;
  logic              r_busy;

  logic              r_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_need;
  logic [ADDR_W-1:0] r_need_addr;
  logic              r_discard;

  logic              w_abort;
  logic [7:0]        w_cmd_byte;
  logic [ADDR_W-1:0] w_addr_new;
  logic              w_cmd_done;
  logic              w_addr_done;
  logic              w_ack_good;
  logic [31:0]       w_word;
  logic              w_word_ok;
  logic [4:0]        w_bit_pos;
  logic              w_last_bit;
  logic              w_fetch_start;
  logic [ADDR_W-1:0] w_fetch_addr;

  assign w_abort     = (r_state != ST_IDLE) && r_ss_s2;
  assign w_cmd_byte  = {r_cmd, r_mosi_s2};
  assign w_addr_new  = {r_addr, r_mosi_s2};
  assign w_cmd_done  = (r_bit_cnt == 6'd7);
  assign w_addr_done = (r_bit_cnt == 6'(ADDR_W - 1));
  assign w_ack_good  = mem_ack && r_req && !r_discard;
  // A word arriving in the same cycle it is first needed is used straight off the bus.
  assign w_word      = r_cur_valid ? r_cur_word : mem_rdata;
  assign w_word_ok   = r_cur_valid || w_ack_good;
  assign w_bit_pos   = {r_byte_idx, r_bit_idx};
  assign w_last_bit  = (r_byte_idx == 2'd3) && (r_bit_idx == 3'd0);

  assign spi_miso     = r_miso;
  assign mem_req      = r_req;
  assign mem_addr     = r_mem_addr;
  assign busy         = r_busy;
  assign err_underrun = r_err;

  // Pin synchronisers and registered sck edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sck_s1  <= 1'b0;
      r_sck_s2  <= 1'b0;
      r_sck_d   <= 1'b0;
      r_ss_s1   <= 1'b1;
      r_ss_s2   <= 1'b1;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
    end else begin
      r_sck_s1  <= spi_sck;
      r_sck_s2  <= r_sck_s1;
      r_sck_d   <= r_sck_s2;
      r_ss_s1   <= spi_ss;
      r_ss_s2   <= r_ss_s1;
      r_mosi_s1 <= spi_mosi;
      r_mosi_s2 <= r_mosi_s1;
      r_rise    <= r_sck_s2 && !r_sck_d;
      r_fall    <= !r_sck_s2 && r_sck_d;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!r_ss_s2) w_state_nxt = ST_CMD;
          else          w_state_nxt = ST_IDLE;
        end
        ST_CMD: begin
          if (r_rise && w_cmd_done) w_state_nxt = (w_cmd_byte == CMD_READ) ? ST_ADDR : ST_IGNORE;
          else                      w_state_nxt = ST_CMD;
        end
        ST_ADDR: begin
          if (r_rise && w_addr_done) w_state_nxt = ST_DATA;
          else                       w_state_nxt = ST_ADDR;
        end
        ST_DATA:   w_state_nxt = ST_DATA;
        ST_IGNORE: w_state_nxt = ST_IGNORE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Fetch triggers: first word after the address, prefetch on entering the last byte.
  always_comb begin
    w_fetch_start = 1'b0;
    w_fetch_addr  = r_word_addr + ADDR_W'(32'd4);
    if (!w_abort && (r_state == ST_ADDR) && r_rise && w_addr_done) begin
      w_fetch_start = 1'b1;
      w_fetch_addr  = {w_addr_new[ADDR_W-1:2], 2'b00};
    end else if (!w_abort && (r_state == ST_DATA) && r_fall && (r_byte_idx == 2'd3) && (r_bit_idx == 3'd7)) begin
      w_fetch_start = 1'b1;
    end else begin
      w_fetch_start = 1'b0;
    end
  end

  // Memory port: one outstanding request; fetches orphaned by ss high are drained and dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_req       <= 1'b0;
      r_mem_addr  <= '0;
      r_need      <= 1'b0;
      r_need_addr <= '0;
      r_discard   <= 1'b0;
    end else begin
      if (r_req && mem_ack) begin
        r_req     <= 1'b0;
        r_discard <= 1'b0;
      end else if (w_abort && r_req) begin
        r_discard <= 1'b1;
      end
      if (w_abort) begin
        r_need <= 1'b0;
      end else if (w_fetch_start) begin
        if (!r_req && !r_need) begin
          r_req      <= 1'b1;
          r_mem_addr <= w_fetch_addr;
        end else begin
          r_need      <= 1'b1;
          r_need_addr <= w_fetch_addr;
        end
      end else if (r_need && !r_req) begin
        r_req      <= 1'b1;
        r_mem_addr <= r_need_addr;
        r_need     <= 1'b0;
      end
    end
  end

  // Command/address shifting, word buffering and MISO streaming.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_bit_cnt    <= 6'd0;
      r_cmd        <= 7'd0;
      r_addr       <= '0;
      r_byte_idx   <= 2'd0;
      r_bit_idx    <= 3'd7;
      r_word_addr  <= '0;
      r_cur_word   <= 32'd0;
      r_cur_valid  <= 1'b0;
      r_hold_word  <= 32'd0;
      r_hold_valid <= 1'b0;
      r_miso       <= 1'b0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != ST_IDLE);
      if ((r_state == ST_IDLE) || w_abort) begin
        r_bit_cnt    <= 6'd0;
        r_cur_valid  <= 1'b0;
        r_hold_valid <= 1'b0;
        r_miso       <= 1'b0;
      end else begin
        case (r_state)
          ST_CMD: begin
            if (r_rise) begin
              r_cmd     <= w_cmd_byte[6:0];
              r_bit_cnt <= w_cmd_done ? 6'd0 : r_bit_cnt + 6'd1;
            end
          end
          ST_ADDR: begin
            if (r_rise) begin
              r_addr    <= w_addr_new[ADDR_W-2:0];
              r_bit_cnt <= r_bit_cnt + 6'd1;
              if (w_addr_done) begin
                r_bit_cnt    <= 6'd0;
                r_byte_idx   <= w_addr_new[1:0];
                r_bit_idx    <= 3'd7;
                r_word_addr  <= {w_addr_new[ADDR_W-1:2], 2'b00};
                r_cur_valid  <= 1'b0;
                r_hold_valid <= 1'b0;
              end
            end
          end
          ST_DATA: begin
            // Returned words fill the current slot first, then the holding register.
            if (w_ack_good && r_cur_valid) begin
              r_hold_word  <= mem_rdata;
              r_hold_valid <= 1'b1;
            end else if (w_ack_good) begin
              r_cur_word  <= mem_rdata;
              r_cur_valid <= 1'b1;
            end
            if (r_fall) begin
              r_miso <= w_word_ok && w_word[w_bit_pos];
              if (!w_word_ok) r_err <= 1'b1;
              if (w_last_bit) begin
                r_cur_word   <= r_hold_valid ? r_hold_word : mem_rdata;
                r_cur_valid  <= r_hold_valid || (w_ack_good && r_cur_valid);
                r_hold_valid <= 1'b0;
                r_byte_idx   <= 2'd0;
                r_bit_idx    <= 3'd7;
                r_word_addr  <= r_word_addr + ADDR_W'(32'd4);
              end else if (r_bit_idx == 3'd0) begin
                r_byte_idx <= r_byte_idx + 2'd1;
                r_bit_idx  <= 3'd7;
              end else begin
                r_bit_idx <= r_bit_idx - 3'd1;
              end
            end
          end
          default: r_miso <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench for spi_flash_responder: an SPI master drives directed reads,
// expected MISO bytes and fetch addresses are queued and checked by monitors.
module tb_spi_flash_responder;

  localparam int HALF = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        spi_sck, spi_ss, spi_mosi, spi_miso;
  logic        mem_req, mem_ack, busy, err_underrun;
  logic [23:0] mem_addr;
  logic [31:0] mem_rdata;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [7:0]  exp_byte_q[$];
  logic [23:0] exp_addr_q[$];
  logic [31:0] mem [logic [23:0]];
  int          lat = 2;
  logic        in_data = 1'b0;

  always #5 clock = ~clock;

  spi_flash_responder dut (
    .clock(clock), .reset(reset),
    .spi_sck(spi_sck), .spi_ss(spi_ss), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .err_underrun(err_underrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // MISO monitor: assembles bytes on master rising edges during data phases.
  initial begin : mon_miso
    logic [7:0] sh;
    int         nb;
    sh = 8'd0;
    nb = 0;
    forever begin
      @(posedge spi_sck);
      if (in_data) begin
        sh = {sh[6:0], spi_miso};
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (exp_byte_q.size() == 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL miso_byte: got %h, no byte expected", sh);
          end else begin
            check("miso_byte", {24'd0, sh}, {24'd0, exp_byte_q.pop_front()});
          end
        end
      end else begin
        nb = 0;
      end
    end
  end

  // Memory model and fetch-address monitor.
  initial begin : mem_model
    logic [23:0] a;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(posedge clock);
      #1;
      if (mem_req === 1'b1) begin
        a = mem_addr;
        if (exp_addr_q.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL mem_addr: got request for %h, none expected", a);
        end else begin
          check("mem_addr", {8'd0, a}, {8'd0, exp_addr_q.pop_front()});
        end
        repeat (lat) @(posedge clock);
        #1;
        mem_ack   = 1'b1;
        mem_rdata = mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
        @(posedge clock);
        #1;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic sck_bit(input logic b);
    spi_mosi = b;
    tick(HALF);
    spi_sck = 1'b1;
    tick(HALF);
    spi_sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) sck_bit(b[i]);
  endtask

  task automatic send_addr(input logic [23:0] a, input int nbits);
    for (int i = 23; i >= 24 - nbits; i--) sck_bit(a[i]);
  endtask

  task automatic read_xfer(input logic [7:0] cmd, input logic [23:0] a, input int nbytes);
    spi_ss = 1'b0;
    tick(HALF);
    check("busy_active", {31'd0, busy}, 32'd1);
    send_byte(cmd);
    send_addr(a, 24);
    in_data = 1'b1;
    for (int i = 0; i < nbytes * 8; i++) sck_bit(1'b0);
    in_data = 1'b0;
    tick(HALF);
    spi_ss = 1'b1;
    tick(48);
    check("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic push4(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    exp_byte_q.push_back(b0); exp_byte_q.push_back(b1);
    exp_byte_q.push_back(b2); exp_byte_q.push_back(b3);
  endtask

  initial begin : stimulus
    reset    = 1'b0;
    spi_sck  = 1'b0;
    spi_ss   = 1'b1;
    spi_mosi = 1'b0;
    tick(4);
    check("rst_miso", {31'd0, spi_miso}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_addr", {8'd0, mem_addr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err_underrun}, 32'd0);
    reset = 1'b1;
    tick(20);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_req", {31'd0, mem_req}, 32'd0);

    // Aligned single word, then prefetch of the following word.
    mem[24'h000004] = 32'h4433_2211;
    push4(8'h11, 8'h22, 8'h33, 8'h44);
    exp_addr_q.push_back(24'h000004); exp_addr_q.push_back(24'h000008);
    read_xfer(8'h03, 24'h000004, 4);
    check("err_after_t1", {31'd0, err_underrun}, 32'd0);

    // Unaligned start crossing into the next word.
    mem[24'h000000] = 32'h4433_2211;
    mem[24'h000004] = 32'h8877_6655;
    push4(8'h33, 8'h44, 8'h55, 8'h66);
    exp_byte_q.push_back(8'h77); exp_byte_q.push_back(8'h88);
    exp_addr_q.push_back(24'h000000); exp_addr_q.push_back(24'h000004); exp_addr_q.push_back(24'h000008);
    read_xfer(8'h03, 24'h000002, 6);

    // Address wrap at the top of the 24-bit space.
    mem[24'hFFFFFC] = 32'hDDCC_BBAA;
    push4(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    push4(8'h11, 8'h22, 8'h33, 8'h44);
    exp_addr_q.push_back(24'hFFFFFC); exp_addr_q.push_back(24'h000000); exp_addr_q.push_back(24'h000004);
    read_xfer(8'h03, 24'hFFFFFC, 8);

    // Unknown command: MISO stays 0, no fetch; then a normal read.
    push4(8'h00, 8'h00, 8'h00, 8'h00);
    read_xfer(8'h0B, 24'h000004, 4);
    push4(8'h55, 8'h66, 8'h77, 8'h88);
    exp_addr_q.push_back(24'h000004); exp_addr_q.push_back(24'h000008);
    read_xfer(8'h03, 24'h000004, 4);
    check("err_after_t4", {31'd0, err_underrun}, 32'd0);

    // Abort mid-address, then a fresh read.
    spi_ss = 1'b0;
    tick(HALF);
    send_byte(8'h03);
    send_addr(24'h000008, 12);
    tick(HALF);
    spi_ss = 1'b1;
    tick(48);
    check("abort_busy", {31'd0, busy}, 32'd0);
    mem[24'h000008] = 32'h0C0B_0A09;
    push4(8'h09, 8'h0A, 8'h0B, 8'h0C);
    exp_addr_q.push_back(24'h000008); exp_addr_q.push_back(24'h00000C);
    read_xfer(8'h03, 24'h000008, 4);
    check("err_after_t5", {31'd0, err_underrun}, 32'd0);

    // First word a full sck period late: leading bit underruns and reads 0.
    lat = 16;
    mem[24'h000010] = 32'hF4F3_F2F1;
    push4(8'h71, 8'hF2, 8'hF3, 8'hF4);
    exp_addr_q.push_back(24'h000010); exp_addr_q.push_back(24'h000014);
    read_xfer(8'h03, 24'h000010, 4);
    check("err_set", {31'd0, err_underrun}, 32'd1);

    // Error stays sticky across a clean transaction.
    lat = 2;
    push4(8'h55, 8'h66, 8'h77, 8'h88);
    exp_addr_q.push_back(24'h000004); exp_addr_q.push_back(24'h000008);
    read_xfer(8'h03, 24'h000004, 4);
    check("err_sticky", {31'd0, err_underrun}, 32'd1);

    tick(20);
    check("bytes_left", 32'(exp_byte_q.size()), 32'd0);
    check("addrs_left", 32'(exp_addr_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
# spi_flash_responder

SPI-mode-0 flash responder for the NPC SoC simulation environment: it sits on the far end of the XIP flash SPI link and answers the standard READ (0x03) command. It decodes command and 24-bit address from MOSI, fetches 32-bit words from a backing memory over a simple req/ack port, and streams the bytes MSB-first on MISO. All SPI pins are oversampled in the system clock domain; no logic is clocked by `spi_sck`.

## Interface

- `CMD_READ`, 8'h03, only command recognised
- `ADDR_W`, 24, address width in bits; the address wraps modulo 2^ADDR_W
- `clock`  input  1  system clock; must run at ≥ 8× the `spi_sck` frequency
- `reset`  input  1  asynchronous, active-low reset
- `spi_sck`  input  1  SPI clock, idle low (mode 0)
- `spi_ss`  input  1  chip select, active low
- `spi_mosi`  input  1  serial data in
- `spi_miso`  output  1  serial data out
- `mem_req`  output  1  word fetch request, held until `mem_ack`
- `mem_addr`  output  ADDR_W  word address, with bits [1:0] always 0
- `mem_rdata`  input  32  fetched word; byte at `mem_addr+k` is `mem_rdata[8k+7:8k]`
- `mem_ack`  input  1  one-cycle pulse; `mem_rdata` is valid in the same cycle
- `busy`  output  1  high whenever state ≠ IDLE
- `err_underrun`  output  1  sticky; set when a data bit is needed before its word arrived; cleared only by reset

## Operation

- Synchronise `spi_sck`, `spi_ss`, `spi_mosi` through 2-FF synchronisers. Detect `sck` rise and fall from the synchronised value and its delayed copy.
- Sample MOSI on a detected rise. Update MISO on a detected fall, and also on the cycle that loads the first data bit.
- States:
  - IDLE: wait for synchronised `ss` low, then go to CMD. Clear the bit counter.
  - CMD: shift 8 bits. If the byte equals CMD_READ, go to ADDR; otherwise go to IGNORE.
  - ADDR: shift 24 bits MSB-first into `addr`.
    - On the 24th rise, issue a fetch of `{addr[23:2],2'b00}` and go to DATA.
    - The start byte index is `addr[1:0]`.
  - DATA: shift out the current word.
    - Each byte goes out MSB-first. Bytes go in increasing byte-index order.
    - After byte 3, continue with byte 0 of the next word.
    - Next word address = current + 4, wrapping at 2^24.
    - The prefetch of the next word issues when the first bit of the current word's last byte is driven. The result lands in a one-word holding register.
  - IGNORE: MISO 0; no fetches. Stay until `ss` goes high.
- In any non-IDLE state, synchronised `ss` high → IDLE next cycle.
  - Counters clear. The holding register is invalidated and MISO goes to 0.
  - An outstanding `mem_req` stays asserted until `mem_ack`; that data is discarded.
  - A new `ss` low while the discarded fetch is still pending is accepted. No new fetch issues until the old ack arrives.
- Underrun: a data bit must be driven while the required word is not yet valid.
  - Drive 0 for that bit and set `err_underrun`.
  - Streaming continues bit-aligned; the late word is used for its remaining bits.
- At most one outstanding fetch at any time.

## Timing

- Reset values: `spi_miso`=0, `mem_req`=0, `mem_addr`=0, `busy`=0, `err_underrun`=0, state IDLE. Synchroniser flops reset to `sck`=0, `ss`=1.
- Pin-to-detect latency is 3 clocks: 2 synchroniser stages plus the edge register.
- MISO changes within 4 clocks of the pin-level `sck` fall. With clock ≥ 8× sck, MISO is stable ≥ 0 clocks before the master's next rising edge.
- `mem_req` rises 1 clock after the detected 24th address rise. It drops the cycle after `mem_ack`.
- First-word deadline: `mem_ack` must arrive before the next detected `sck` fall, roughly half an sck period. Arriving later triggers underrun.
- `busy` rises 1 clock after synchronised `ss` low. It falls 1 clock after synchronised `ss` high.
- Simultaneous `mem_ack` and the first-bit load in the same cycle: use `mem_rdata` directly. This is not an underrun.

## Test plan

- Reset with pins idle → all outputs 0. Hold `sck` low for 20 clocks → `busy`=0, no `mem_req`.
- Send 0x03 then address 0x000004; memory returns 0x44332211 with 2-clock latency → `mem_addr`=0x000004 and MISO bytes 0x11, 0x22, 0x33, 0x44. `err_underrun`=0.
- Send 0x03 then address 0x000002, clocking 6 data bytes; memory at 0x0→0x44332211, 0x4→0x88776655 → MISO 0x33,0x44,0x55,0x66,0x77,0x88. `mem_addr` sequence is 0x0, 0x4, 0x8 (the 0x8 fetch is a prefetch).
- Send 0x03 then address 0xFFFFFC, clocking 8 bytes → second fetch `mem_addr`=0x000000 (wrap).
- Send command 0x0B plus 24 address bits and 32 clocks → no `mem_req`, MISO 0 throughout; a following 0x03 transaction reads correctly.
- Raise `ss` after 12 address bits, then start a new 0x03/0x000008 read → correct data. Separately, delay `mem_ack` by one full sck period → first bit 0 and `err_underrun`=1, held through later transactions.
